// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Types and constants shared by the PWM fader, the pulse generators and the
// PWM decoder, so that all of them agree on counter width and the stuck-line
// timeout.
//   pwm_state_e    : measurement state (ST_IDLE waits for a rise, ST_MEAS
//                    measures from one rise to the next)
//   PWM_CNT_W      : default width of the period / high-time counters
//   PWM_MAX_PERIOD : default timeout in cycles without a rising edge
//   PWM_FILT_LEN   : default glitch-filter agreement length in cycles
//   cnt_step       : one-step increment of a measurement counter
// -----------------------------------------------------------------------------
package pwm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } pwm_state_e;

  localparam int PWM_CNT_W      = 14;
  localparam int PWM_MAX_PERIOD = 14000;
  localparam int PWM_FILT_LEN   = 4;

  // Counters are sized so the timeout always fires before they could wrap,
  // so a plain increment is sufficient.
  function automatic logic [PWM_CNT_W-1:0] cnt_step(input logic [PWM_CNT_W-1:0] val);
    return val + {{(PWM_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// -----------------------------------------------------------------------------
// pwm_in_sync
// Brings the asynchronous PWM pin into the clock domain and detects rising
// edges on the resulting level.
//   Optional build macro: PWM_DECODER_GLITCH_FILTER_EN
//     defined   -> the synchronized level passes an agreement filter and only
//                  changes after FILT_LEN consecutive equal samples; edge
//                  detection runs on the filtered level.
//     undefined -> the synchronized level is used directly (FILT_LEN unused).
// Ports:
//   i_clk    in  system clock, rising edge
//   i_rst    in  synchronous active-high reset
//   i_pwm    in  asynchronous PWM input
//   o_level  out synchronized (optionally filtered) input level
//   o_rise   out one-cycle pulse on a 0->1 transition of o_level
// -----------------------------------------------------------------------------
module pwm_in_sync #(
  parameter int FILT_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int AGREE_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic               r_filt;
  logic [AGREE_W-1:0] r_agree;

  // Agreement filter: r_agree counts consecutive samples that disagree with
  // the current filtered level; any agreeing sample restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_filt  <= 1'b0;
      r_agree <= {AGREE_W{1'b0}};
    end else if (r_sync2 == r_filt) begin
      r_agree <= {AGREE_W{1'b0}};
    end else if (r_agree == AGREE_W'(FILT_LEN - 1)) begin
      r_filt  <= r_sync2;
      r_agree <= {AGREE_W{1'b0}};
    end else begin
      r_agree <= r_agree + {{(AGREE_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_level = r_filt;
`else
  logic w_unused_filt_len;

  assign w_level           = r_sync2;
  assign w_unused_filt_len = ^FILT_LEN;
`endif

  // Edge register holding the level seen in the previous cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;

endmodule

// File: rtl/pwm_decoder.sv
// -----------------------------------------------------------------------------
// pwm_decoder
// Measures a PWM / pulse stream: for every complete cycle (rise to rise) it
// reports the number of high cycles and the period, and flags a line that has
// stopped toggling (0 % / 100 % duty or a dead source).
//   Optional build macro: PWM_DECODER_GLITCH_FILTER_EN (see pwm_in_sync)
// Parameters:
//   CNT_W      counter / result width
//   MAX_PERIOD cycles without a rise before the line is declared stuck
//              (must be < 2**CNT_W)
//   FILT_LEN   glitch-filter length, only used with the filter compiled in
// Ports:
//   i_clk          in  system clock, rising edge
//   i_rst          in  synchronous active-high reset
//   i_pwm_in       in  asynchronous PWM input
//   o_high_cnt     out high-time cycles of the last complete period
//   o_period       out cycles between the last two rises
//   o_valid        out one-cycle strobe, o_high_cnt/o_period updated
//   o_stuck        out no rise within MAX_PERIOD cycles
//   o_stuck_level  out synced input level when o_stuck was raised
// -----------------------------------------------------------------------------
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W      = PWM_CNT_W,
  parameter int MAX_PERIOD = PWM_MAX_PERIOD,
  parameter int FILT_LEN   = PWM_FILT_LEN
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pwm_in,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_stuck,
  output logic             o_stuck_level
);

  logic w_level;
  logic w_rise;
  logic w_at_max;

  pwm_state_e r_state;
  pwm_state_e w_state_nxt;

  // FSM action strobes
  logic w_start;     // (re)start counting from a rise
  logic w_capture;   // publish the finished period
  logic w_timeout;   // no rise within MAX_PERIOD
  logic w_count;     // ordinary measurement cycle

  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_stuck;
  logic             r_stuck_level;

  pwm_in_sync #(
    .FILT_LEN (FILT_LEN)
  ) u_in_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_pwm   (i_pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  assign w_at_max = (r_pcnt == CNT_W'(MAX_PERIOD));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a rise always takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_MEAS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MEAS: begin
        if (w_rise) begin
          w_state_nxt = ST_MEAS;
        end else if (w_at_max) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_MEAS;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM action decode. The first rise seen in IDLE only arms the
  // measurement; a result is only published for a rise seen in MEAS.
  always_comb begin
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    w_count   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_start = 1'b1;
        end else begin
          w_start = 1'b0;
        end
      end
      ST_MEAS: begin
        if (w_rise) begin
          w_capture = 1'b1;
          w_start   = 1'b1;
        end else if (w_at_max) begin
          w_timeout = 1'b1;
        end else begin
          w_count = 1'b1;
        end
      end
      default: begin
        w_start = 1'b0;
      end
    endcase
  end

  // Period and high-time counters. Both load 1 on a rise because the rise
  // cycle itself is the first (high) cycle of the new period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pcnt <= {CNT_W{1'b0}};
      r_hcnt <= {CNT_W{1'b0}};
    end else if (w_start) begin
      r_pcnt <= CNT_W'(1);
      r_hcnt <= CNT_W'(1);
    end else if (w_count) begin
      r_pcnt <= cnt_step(r_pcnt);
      if (w_level) begin
        r_hcnt <= cnt_step(r_hcnt);
      end
    end
  end

  // Result registers and the valid strobe; results hold between strobes and
  // across a timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_high_cnt <= {CNT_W{1'b0}};
      r_period   <= {CNT_W{1'b0}};
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_high_cnt <= r_hcnt;
        r_period   <= r_pcnt;
      end
    end
  end

  // Stuck flag: raised on timeout with the level at that moment, cleared by
  // the next rise. The captured level is kept after the flag clears.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stuck       <= 1'b0;
      r_stuck_level <= 1'b0;
    end else if (w_timeout) begin
      r_stuck       <= 1'b1;
      r_stuck_level <= w_level;
    end else if (w_start) begin
      r_stuck <= 1'b0;
    end
  end

  assign o_high_cnt    = r_high_cnt;
  assign o_period      = r_period;
  assign o_valid       = r_valid;
  assign o_stuck       = r_stuck;
  assign o_stuck_level = r_stuck_level;

endmodule

// File: tb/tb_pwm_decoder.sv
// -----------------------------------------------------------------------------
// tb_pwm_decoder
// Directed and randomized PWM streams against a reference model that works
// from rise times: a period is the cycle distance between consecutive rises
// of the synchronized level, the high time is the number of high cycles in
// that span, and a span reaching MAX_PERIOD with no rise means a stuck line.
// -----------------------------------------------------------------------------
module tb_pwm_decoder;

  localparam int CNT_W      = 14;
  localparam int MAX_PERIOD = 14000;
  localparam int FILT_LEN   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwm = 1'b0;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             stuck;
  logic             stuck_level;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic        h1 = 1'b0;   // pin value sampled at the last edge
  logic        h2 = 1'b0;   // synchronized level (pin two samples back)
  logic        h3 = 1'b0;   // synchronized level one cycle earlier
  logic        m_armed = 1'b0;
  int          m_cyc = 0;
  int          m_last_rise = 0;
  int          m_highs = 0;
  logic [31:0] e_high = 32'd0;
  logic [31:0] e_period = 32'd0;
  logic        e_valid = 1'b0;
  logic        e_stuck = 1'b0;
  logic        e_stuck_level = 1'b0;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  logic        f_lvl = 1'b0;
  logic        f_prev = 1'b0;
  logic        win[$];
`endif

  always #5 clk = ~clk;

  pwm_decoder #(
    .CNT_W      (CNT_W),
    .MAX_PERIOD (MAX_PERIOD),
    .FILT_LEN   (FILT_LEN)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pwm_in      (pwm),
    .o_high_cnt    (high_cnt),
    .o_period      (period),
    .o_valid       (valid),
    .o_stuck       (stuck),
    .o_stuck_level (stuck_level)
  );

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, m_cyc, obs, exp);
      $error("check %s disagrees", tag);
    end
    if (errors >= 40) finish_run();
  endtask

  // One clock cycle: drive inputs, clock, compare, then advance the model.
  task automatic step(input logic v, input logic r);
    logic lvl;
    logic lvl_prev;
    logic rise;
    logic all_flip;
    pwm = v;
    rst = r;
    @(posedge clk);
    #1;
    m_cyc++;
    if (r) begin
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      m_armed = 1'b0;
      e_high = 32'd0; e_period = 32'd0;
      e_valid = 1'b0; e_stuck = 1'b0; e_stuck_level = 1'b0;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
      f_lvl = 1'b0; f_prev = 1'b0;
      win.delete();
`endif
    end else begin
`ifdef PWM_DECODER_GLITCH_FILTER_EN
      win.push_back(h2);
      if (win.size() > FILT_LEN) void'(win.pop_front());
      f_prev = f_lvl;
      all_flip = (win.size() == FILT_LEN);
      foreach (win[i]) if (win[i] == f_lvl) all_flip = 1'b0;
      if (all_flip) f_lvl = ~f_lvl;
`else
      all_flip = 1'b0;
`endif
      h3 = h2;
      h2 = h1;
      h1 = v;
    end

    chk("valid", {31'd0, valid}, {31'd0, e_valid});
    chk("stuck", {31'd0, stuck}, {31'd0, e_stuck});
    chk("stuck_level", {31'd0, stuck_level}, {31'd0, e_stuck_level});
    chk("high_cnt", {18'd0, high_cnt}, e_high);
    chk("period", {18'd0, period}, e_period);

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    lvl = f_lvl;
    lvl_prev = f_prev;
`else
    lvl = h2;
    lvl_prev = h3;
`endif
    rise = lvl & ~lvl_prev;
    e_valid = 1'b0;
    if (rise) begin
      if (m_armed) begin
        e_valid  = 1'b1;
        e_period = m_cyc - m_last_rise;
        e_high   = m_highs;
      end
      e_stuck = 1'b0;
      m_armed = 1'b1;
      m_last_rise = m_cyc;
      m_highs = 1;
    end else if (m_armed) begin
      if (m_cyc - m_last_rise == MAX_PERIOD) begin
        e_stuck = 1'b1;
        e_stuck_level = lvl;
        m_armed = 1'b0;
      end else if (lvl) begin
        m_highs++;
      end
    end
  endtask

  task automatic run_level(input logic v, input int n);
    repeat (n) step(v, 1'b0);
  endtask

  task automatic pwm_periods(input int hi, input int lo, input int n);
    repeat (n) begin
      run_level(1'b1, hi);
      run_level(1'b0, lo);
    end
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // 3 high / 7 low
    pwm_periods(3, 7, 10);
`ifndef PWM_DECODER_GLITCH_FILTER_EN
    chk("plan_3_7_high", {18'd0, high_cnt}, 32'd3);
    chk("plan_3_7_period", {18'd0, period}, 32'd10);
`endif

    // Period exactly MAX_PERIOD, 50 % duty; the rise coincides with the timeout
    pwm_periods(7000, 7000, 2);
    run_level(1'b1, 100);
    chk("max_period_high", {18'd0, high_cnt}, 32'd7000);
    chk("max_period_period", {18'd0, period}, 32'd14000);
    chk("max_period_no_stuck", {31'd0, stuck}, 32'd0);

    // Held high -> stuck at 1, results retained
    run_level(1'b1, 19900);
    chk("stuck_high_flag", {31'd0, stuck}, 32'd1);
    chk("stuck_high_level", {31'd0, stuck_level}, 32'd1);
    chk("stuck_high_keep", {18'd0, period}, 32'd14000);

    // Restart after stuck: first rise clears STUCK without a strobe
    run_level(1'b0, 10);
    pwm_periods(3, 7, 10);
    chk("stuck_cleared", {31'd0, stuck}, 32'd0);

    // Random streams, including sub-minimum pulses
    repeat (40) pwm_periods($urandom_range(1, 12), $urandom_range(1, 12), 1);

    // Reset in the middle of a high phase
    pwm_periods(6, 6, 4);
    run_level(1'b1, 3);
    step(1'b1, 1'b1);
    chk("mid_reset_high", {18'd0, high_cnt}, 32'd0);
    chk("mid_reset_period", {18'd0, period}, 32'd0);
    run_level(1'b1, 3);
    run_level(1'b0, 6);
    pwm_periods(6, 6, 3);
    chk("post_reset_high", {18'd0, high_cnt}, 32'd6);
    chk("post_reset_period", {18'd0, period}, 32'd12);

    // 5/5 stream with 2-cycle glitches
    repeat (8) begin
      run_level(1'b1, 5);
      run_level(1'b0, 1);
      run_level(1'b1, 2);
      run_level(1'b0, 2);
    end
    pwm_periods(5, 5, 3);

    // Held low -> stuck at 0
    run_level(1'b0, 14100);
    chk("stuck_low_flag", {31'd0, stuck}, 32'd1);
    chk("stuck_low_level", {31'd0, stuck_level}, 32'd0);

    pwm_periods(4, 4, 3);
    finish_run();
  end

endmodule
